lrc_frame_arbiter: RTL and testbench

- Shares one LRC (longitudinal redundancy check) accumulator between two byte-stream requesters.
- Each requester sends a frame of bytes using valid/ready handshakes. The arbiter locks the accumulator to one requester for a whole frame.
- When the frame ends, the block finalises the checksum as the two's complement of the byte sum mod 256. It presents the checksum, the frame length and the requester ID on a result port with its own valid/ready handshake.
- Sits between the host-side byte sources and the checksum output register bank.

---
 rtl/lrc_frame_arbiter_pkg.sv | 18 +
 rtl/lrc_frame_arbiter_if.sv | 37 +++
 rtl/lrc_frame_arbiter_accum.sv | 33 +++
 rtl/lrc_frame_arbiter.sv | 136 +++++++++++++
 tb/tb_lrc_frame_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lrc_frame_arbiter_pkg.sv
// Shared types, widths and the checksum finalise helper for the LRC frame arbiter.
package lrc_pkg;

   localparam int LRC_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      RESULT = 2'd2
   } lrc_state_e;

   // The LRC is the two's complement of the byte sum, so that adding it back
   // to the frame sum yields zero.
   function automatic logic [LRC_W-1:0] lrc_finalize(input logic [LRC_W-1:0] sum);
      return (~sum) + LRC_W'(1);
   endfunction

endpackage

// File: rtl/lrc_frame_arbiter_if.sv
// Byte-stream request channels and the result channel of the LRC frame arbiter.
interface lrc_frame_arbiter_if #(
   parameter int LEN_W = 8
);
   logic             req0_valid;
   logic [7:0]       req0_data;
   logic             req0_last;
   logic             req0_ready;
   logic             req1_valid;
   logic [7:0]       req1_data;
   logic             req1_last;
   logic             req1_ready;
   logic             res_valid;
   logic [7:0]       res_data;
   logic             res_id;
   logic [LEN_W-1:0] res_len;
   logic             res_ready;
   logic             busy;

   // Host side: byte sources and result consumer.
   modport master (
      output req0_valid, req0_data, req0_last,
      output req1_valid, req1_data, req1_last,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_data, res_id, res_len, busy
   );

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_data, req0_last,
      input  req1_valid, req1_data, req1_last,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_data, res_id, res_len, busy
   );
endinterface

// File: rtl/lrc_frame_arbiter_accum.sv
// Running byte-sum accumulator; also offers the finalised LRC of the sum that
// would result from accepting the current byte.
module lrc_accum
   import lrc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic [LRC_W-1:0] i_data,
   output logic [LRC_W-1:0] o_sum,
   output logic [LRC_W-1:0] o_final
);

   logic [LRC_W-1:0] r_acc;
   logic [LRC_W-1:0] w_next;

   assign w_next  = r_acc + i_data;
   assign o_sum   = r_acc;
   assign o_final = lrc_finalize(w_next);

   // Clear at the start of each frame, otherwise add every accepted byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_next;
      end
   end

endmodule

// File: rtl/lrc_frame_arbiter.sv
// Two-requester round-robin arbiter that locks one shared LRC accumulator for
// a whole frame and hands the finalised checksum out on a result channel.
module lrc_frame_arbiter
   import lrc_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   lrc_frame_arbiter_if.slave bus
);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_STREAM = STREAM;
   localparam logic [1:0] S_RESULT = RESULT;

   logic [1:0]       r_state;
   logic             r_grant_id;
   logic             r_last_grant;
   logic             r_req0_ready;
   logic             r_req1_ready;
   logic             r_res_valid;
   logic [7:0]       r_res_data;
   logic             r_res_id;
   logic [LEN_W-1:0] r_res_len;
   logic [LEN_W-1:0] r_count;
   logic             r_busy;

   logic             w_beat;
   logic [7:0]       w_data;
   logic             w_last;
   logic             w_any_req;
   logic             w_grant_next;
   logic             w_clear;
   logic [7:0]       w_final;
   logic [7:0]       w_sum_unused;

   // Select the locked requester's channel and decide who wins the next grant;
   // on a tie the requester that was not granted last time goes first.
   always_comb begin
      w_beat       = 1'b0;
      w_data       = bus.req0_data;
      w_last       = bus.req0_last;
      w_grant_next = 1'b0;
      if (r_grant_id) begin
         w_beat = bus.req1_valid & r_req1_ready;
         w_data = bus.req1_data;
         w_last = bus.req1_last;
      end else begin
         w_beat = bus.req0_valid & r_req0_ready;
      end
      if (bus.req0_valid && bus.req1_valid) begin
         w_grant_next = ~r_last_grant;
      end else if (bus.req1_valid) begin
         w_grant_next = 1'b1;
      end
   end

   assign w_any_req = bus.req0_valid | bus.req1_valid;
   assign w_clear   = (r_state == S_IDLE) & w_any_req;

   lrc_accum u_accum (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_en    (w_beat),
      .i_data  (w_data),
      .o_sum   (w_sum_unused),
      .o_final (w_final)
   );

   // Frame FSM: grant in IDLE, count beats in STREAM, hold the result until
   // the consumer takes it. Ready and busy are registered state decodes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_grant_id   <= 1'b0;
         r_last_grant <= 1'b1;
         r_req0_ready <= 1'b0;
         r_req1_ready <= 1'b0;
         r_res_valid  <= 1'b0;
         r_res_data   <= '0;
         r_res_id     <= 1'b0;
         r_res_len    <= '0;
         r_count      <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant_id   <= w_grant_next;
                  r_last_grant <= w_grant_next;
                  r_count      <= '0;
                  r_req0_ready <= ~w_grant_next;
                  r_req1_ready <= w_grant_next;
                  r_busy       <= 1'b1;
                  r_state      <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (w_beat) begin
                  r_count <= r_count + LEN_W'(1);
                  if (w_last) begin
                     r_res_data   <= w_final;
                     r_res_len    <= r_count + LEN_W'(1);
                     r_res_id     <= r_grant_id;
                     r_res_valid  <= 1'b1;
                     r_req0_ready <= 1'b0;
                     r_req1_ready <= 1'b0;
                     r_state      <= S_RESULT;
                  end
               end
            end
            S_RESULT: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req0_ready = r_req0_ready;
   assign bus.req1_ready = r_req1_ready;
   assign bus.res_valid  = r_res_valid;
   assign bus.res_data   = r_res_data;
   assign bus.res_id     = r_res_id;
   assign bus.res_len    = r_res_len;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_lrc_frame_arbiter.sv
// Testbench for lrc_frame_arbiter: directed frames plus randomized frames,
// checked against a frame-level checksum model.
module tb_lrc_frame_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   passed;
   int   timeouts;
   int   bothReady;
   int   resValidCycles;
   bit   randReady;
   logic [16:0] expQ[$];
   logic [16:0] gotQ[$];

   lrc_frame_arbiter_if #(.LEN_W(8)) bus ();

   lrc_frame_arbiter #(.LEN_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watch the result channel and the ready lines away from the clock edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.req0_ready && bus.req1_ready) bothReady++;
         if (bus.res_valid) resValidCycles++;
         if (bus.res_valid && bus.res_ready)
            gotQ.push_back({bus.res_id, bus.res_len, bus.res_data});
      end
   end

   // Optional random back-pressure on the result consumer.
   always @(posedge clk) begin
      #1;
      if (randReady) bus.res_ready = 1'($urandom_range(1, 0));
   end

   // Hard stop in case something stalls beyond every per-step bound.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic setReq(input int id, input logic v, input logic [7:0] d, input logic l);
      if (id == 0) begin
         bus.req0_valid = v;
         bus.req0_data  = d;
         bus.req0_last  = l;
      end else begin
         bus.req1_valid = v;
         bus.req1_data  = d;
         bus.req1_last  = l;
      end
   endtask

   // Drive one frame on a requester, honouring ready, with optional random
   // idle cycles before each beat.
   task automatic applyStimulus(input int id, input logic [7:0] b[16], input int n,
                                input bit doLast, input int maxGap);
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
         if (gap > 0) begin
            setReq(id, 1'b0, 8'h00, 1'b0);
            repeat (gap) begin @(posedge clk); #1; end
         end
         setReq(id, 1'b1, b[i], doLast && (i == n - 1));
         begin
            int k;
            k = 0;
            while (!((id == 0) ? bus.req0_ready : bus.req1_ready) && k < 500) begin
               @(posedge clk); #1;
               k++;
            end
            if (k >= 500) timeouts++;
            else begin @(posedge clk); #1; end
         end
      end
      setReq(id, 1'b0, 8'h00, 1'b0);
   endtask

   // Frame-level reference: checksum is whatever makes the byte sum zero mod 256.
   task automatic pushExp(input int id, input logic [7:0] b[16], input int n);
      int s;
      int d;
      s = 0;
      for (int i = 0; i < n; i++) s += int'(b[i]);
      d = (256 - (s % 256)) % 256;
      expQ.push_back({1'(id), 8'(n % 256), 8'(d)});
   endtask

   task automatic checkResults(input string tag);
      int k;
      k = 0;
      while (gotQ.size() < expQ.size() && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      checkOutput({tag, "_count"}, 32'(gotQ.size()), 32'(expQ.size()));
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         logic [16:0] e;
         logic [16:0] g;
         e = expQ.pop_front();
         g = gotQ.pop_front();
         checkOutput({tag, "_id"},   32'(g[16]),    32'(e[16]));
         checkOutput({tag, "_len"},  32'(g[15:8]),  32'(e[15:8]));
         checkOutput({tag, "_data"}, 32'(g[7:0]),   32'(e[7:0]));
      end
      expQ.delete();
      gotQ.delete();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_res_valid"},  32'(bus.res_valid),  0);
      checkOutput({tag, "_res_data"},   32'(bus.res_data),   0);
      checkOutput({tag, "_res_id"},     32'(bus.res_id),     0);
      checkOutput({tag, "_res_len"},    32'(bus.res_len),    0);
      checkOutput({tag, "_req0_ready"}, 32'(bus.req0_ready), 0);
      checkOutput({tag, "_req1_ready"}, 32'(bus.req1_ready), 0);
      checkOutput({tag, "_busy"},       32'(bus.busy),       0);
   endtask

   initial begin
      logic [7:0] fa[16];
      logic [7:0] fb[16];
      logic [7:0] hd;
      logic       hid;
      logic [7:0] hlen;
      int         stableErr;
      int         k;

      checks = 0; passed = 0; timeouts = 0; bothReady = 0; resValidCycles = 0;
      randReady = 1'b0;
      for (int i = 0; i < 16; i++) begin fa[i] = 8'h00; fb[i] = 8'h00; end
      rst_n = 1'b0;
      setReq(0, 1'b0, 8'h00, 1'b0);
      setReq(1, 1'b0, 8'h00, 1'b0);
      bus.res_ready = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Req0 frame 01 02 03.
      resValidCycles = 0;
      fa[0] = 8'h01; fa[1] = 8'h02; fa[2] = 8'h03;
      pushExp(0, fa, 3);
      applyStimulus(0, fa, 3, 1'b1, 0);
      checkResults("req0_basic");
      checkOutput("req0_basic_valid_cycles", 32'(resValidCycles), 1);

      // Req1 frame FF 01, then single-byte frame 80.
      fa[0] = 8'hFF; fa[1] = 8'h01;
      pushExp(1, fa, 2);
      applyStimulus(1, fa, 2, 1'b1, 0);
      fa[0] = 8'h80;
      pushExp(1, fa, 1);
      applyStimulus(1, fa, 1, 1'b1, 0);
      checkResults("req1_wrap");

      // Both requesters busy: round-robin order id0, id1, id0, id1.
      fa[0] = 8'h10; fa[1] = 8'h20;
      pushExp(0, fa, 2); pushExp(1, fa, 2); pushExp(0, fa, 2); pushExp(1, fa, 2);
      bothReady = 0;
      fork
         begin
            applyStimulus(0, fa, 2, 1'b1, 0);
            applyStimulus(0, fa, 2, 1'b1, 0);
         end
         begin
            applyStimulus(1, fa, 2, 1'b1, 0);
            applyStimulus(1, fa, 2, 1'b1, 0);
         end
      join
      checkResults("round_robin");
      checkOutput("round_robin_both_ready", 32'(bothReady), 0);

      // Zero and repeated bytes with idle gaps between beats.
      fa[0] = 8'h00; fa[1] = 8'h00; fa[2] = 8'h05; fa[3] = 8'h05;
      pushExp(0, fa, 4);
      applyStimulus(0, fa, 4, 1'b1, 3);
      checkResults("gaps");

      // Result held while the consumer stalls.
      bus.res_ready = 1'b0;
      fa[0] = 8'h11; fa[1] = 8'h22;
      pushExp(0, fa, 2);
      applyStimulus(0, fa, 2, 1'b1, 0);
      k = 0;
      while (!bus.res_valid && k < 100) begin @(posedge clk); #1; k++; end
      checkOutput("hold_res_valid", 32'(bus.res_valid), 1);
      hd = bus.res_data; hid = bus.res_id; hlen = bus.res_len;
      stableErr = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.res_valid !== 1'b1 || bus.res_data !== hd || bus.res_id !== hid ||
             bus.res_len !== hlen || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            stableErr++;
      end
      checkOutput("hold_stable", 32'(stableErr), 0);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("hold_release_busy", 32'(bus.busy), 0);
      checkOutput("hold_release_valid", 32'(bus.res_valid), 0);
      fb[0] = 8'h40; fb[1] = 8'h41; fb[2] = 8'h42;
      pushExp(1, fb, 3);
      applyStimulus(1, fb, 3, 1'b1, 0);
      checkResults("hold");

      // Reset in the middle of a frame.
      fa[0] = 8'h33; fa[1] = 8'h44;
      applyStimulus(0, fa, 2, 1'b0, 0);
      checkOutput("midreset_locked", 32'(bus.req0_ready), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkAllZero("midreset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      fa[0] = 8'h07;
      pushExp(0, fa, 1);
      applyStimulus(0, fa, 1, 1'b1, 0);
      checkResults("after_reset");

      // Randomized frames with random gaps and consumer back-pressure.
      randReady = 1'b1;
      bothReady = 0;
      for (int f = 0; f < 24; f++) begin
         int id;
         int n;
         id = int'($urandom_range(1, 0));
         n  = int'($urandom_range(12, 1));
         for (int i = 0; i < 16; i++) fa[i] = 8'($urandom);
         pushExp(id, fa, n);
         applyStimulus(id, fa, n, 1'b1, 2);
      end
      checkResults("random");
      randReady = 1'b0;
      #2;
      bus.res_ready = 1'b1;
      checkOutput("random_both_ready", 32'(bothReady), 0);
      checkOutput("driver_timeouts", 32'(timeouts), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
